// File: rtl/wait_state_memory.sv
// rtl/wait_state_memory.sv - single-port memory with read/write wait states and a write-protected region
module wait_state_memory #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       RD_WAIT  = 1,
  parameter int unsigned       WR_WAIT  = 0,
  parameter int unsigned       ROM_BASE = 16'hFFF0,
  parameter int unsigned       ROM_SIZE = 16,
  parameter logic [DATA_W-1:0] FILL     = 8'hA5,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              cpu_clk,
  input  logic              cpu_reset,
  input  logic              cpu_oe_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              mem_ready_o,
  output logic              wp_fault_o,
  output logic              bus_err_o,
  output logic [CNT_W-1:0]  rd_count_o,
  output logic [CNT_W-1:0]  wr_count_o
);

  localparam int unsigned       DEPTH      = 2 ** ADDR_W;
  // Mask-and-compare keeps the range check inside ADDR_W bits even when the
  // protected block ends exactly at the top of the address space.
  localparam logic [ADDR_W-1:0] ROM_MASK   = ~ADDR_W'(ROM_SIZE - 1);
  localparam logic [ADDR_W-1:0] ROM_BASE_A = ADDR_W'(ROM_BASE);
  localparam logic [3:0]        RD_N       = 4'(RD_WAIT);
  localparam logic [3:0]        WR_N       = 4'(WR_WAIT);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_HOLD} state_t;

  state_t            state, state_n;
  logic [3:0]        wait_cnt, wait_cnt_n, load_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              is_wr_q;
  logic              take, ack, err_n, in_rom;

  logic [DATA_W-1:0] mem [DEPTH] = '{default: FILL};

  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    take       = 1'b0;
    ack        = 1'b0;
    err_n      = 1'b0;
    load_cnt   = cpu_oe_i ? RD_N : WR_N;
    case (state)
      ST_IDLE: begin
        if (cpu_oe_i ^ cpu_we_i) begin
          take       = 1'b1;
          wait_cnt_n = load_cnt;
          state_n    = (load_cnt != 4'd0) ? ST_WAIT : ST_ACK;
        end else if (cpu_oe_i && cpu_we_i) begin
          err_n   = 1'b1;
          state_n = ST_HOLD;
        end
      end
      ST_WAIT: begin
        wait_cnt_n = wait_cnt - 4'd1;
        if (wait_cnt == 4'd1) state_n = ST_ACK;
      end
      ST_ACK: begin
        ack     = 1'b1;
        state_n = ST_HOLD;
      end
      ST_HOLD: begin
        if (!cpu_oe_i && !cpu_we_i) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign in_rom = (addr_q & ROM_MASK) == ROM_BASE_A;

  always_ff @(posedge cpu_clk) begin
    if (cpu_reset) begin
      state       <= ST_IDLE;
      wait_cnt    <= 4'd0;
      cpu_data_o  <= '0;
      mem_ready_o <= 1'b0;
      wp_fault_o  <= 1'b0;
      bus_err_o   <= 1'b0;
      rd_count_o  <= '0;
      wr_count_o  <= '0;
    end else begin
      state       <= state_n;
      wait_cnt    <= wait_cnt_n;
      mem_ready_o <= ack;
      wp_fault_o  <= ack && is_wr_q && in_rom;
      bus_err_o   <= err_n;
      if (ack && !is_wr_q) begin
        cpu_data_o <= mem[addr_q];
        if (rd_count_o != '1) rd_count_o <= rd_count_o + CNT_W'(1);
      end
      if (ack && is_wr_q && wr_count_o != '1) wr_count_o <= wr_count_o + CNT_W'(1);
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (take) begin
      addr_q  <= cpu_addr_i;
      data_q  <= cpu_data_i;
      is_wr_q <= cpu_we_i;
    end
  end

  // The array is deliberately outside the reset domain.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_reset && ack && is_wr_q && !in_rom) mem[addr_q] <= data_q;
  end

endmodule

// File: tb/tb_wait_state_memory.sv
// tb/tb_wait_state_memory.sv - scoreboard bench for wait_state_memory (default and slow/narrow-counter instances)
module tb_wait_state_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1, oe_a = 1'b0, we_a = 1'b0;
  logic [15:0] addr_a = '0;
  logic [7:0]  din_a = '0, dout_a;
  logic        rdy_a, wp_a, err_a;
  logic [15:0] rdc_a, wrc_a;

  logic        rst_b = 1'b1, oe_b = 1'b0, we_b = 1'b0;
  logic [15:0] addr_b = '0;
  logic [7:0]  din_b = '0, dout_b;
  logic        rdy_b, wp_b, err_b;
  logic [1:0]  rdc_b, wrc_b;

  wait_state_memory dut_a (
    .cpu_clk(clk), .cpu_reset(rst_a), .cpu_oe_i(oe_a), .cpu_we_i(we_a),
    .cpu_addr_i(addr_a), .cpu_data_i(din_a), .cpu_data_o(dout_a),
    .mem_ready_o(rdy_a), .wp_fault_o(wp_a), .bus_err_o(err_a),
    .rd_count_o(rdc_a), .wr_count_o(wrc_a)
  );

  wait_state_memory #(.RD_WAIT(3), .WR_WAIT(2), .FILL(8'h10), .CNT_W(2)) dut_b (
    .cpu_clk(clk), .cpu_reset(rst_b), .cpu_oe_i(oe_b), .cpu_we_i(we_b),
    .cpu_addr_i(addr_b), .cpu_data_i(din_b), .cpu_data_o(dout_b),
    .mem_ready_o(rdy_b), .wp_fault_o(wp_b), .bus_err_o(err_b),
    .rd_count_o(rdc_b), .wr_count_o(wrc_b)
  );

  typedef struct {
    int         cyc;
    bit         err;
    bit         wp;
    bit         rd;
    logic [7:0] dout;
    int         rdc;
    int         wrc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int rd_wait [2] = '{1, 3};
  int wr_wait [2] = '{0, 2};
  int cnt_max [2] = '{65535, 3};

  logic [7:0] mmem [2][65536];
  int         m_rdc [2];
  int         m_wrc [2];
  logic [7:0] m_dout [2];

  int cyc   = 0;
  int n_vec = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit in_rom(logic [15:0] a);
    int v;
    v = int'(a);
    return (v >= 32'hFFF0) && (v <= 32'hFFF0 + 16 - 1);
  endfunction

  function automatic int inc_sat(int v, int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, want, cyc);
    end
  endtask

  task automatic drive(int d, logic oe, logic we, logic [15:0] a, logic [7:0] v);
    if (d == 0) begin
      oe_a = oe; we_a = we; addr_a = a; din_a = v;
    end else begin
      oe_b = oe; we_b = we; addr_b = a; din_b = v;
    end
  endtask

  task automatic set_rst(int d, logic r);
    if (d == 0) rst_a = r;
    else rst_b = r;
  endtask

  task automatic model_reset(int d);
    m_rdc[d]  = 0;
    m_wrc[d]  = 0;
    m_dout[d] = 8'h00;
    if (d == 0) q_a.delete();
    else q_b.delete();
  endtask

  // Monitor side: one pop-and-compare per observed strobe, plus overdue detection.
  task automatic check_port(int d, logic rdy, logic wp, logic err, logic [7:0] dout,
                            logic [15:0] rdc, logic [15:0] wrc);
    exp_t e;
    int   sz;
    sz = (d == 0) ? q_a.size() : q_b.size();
    if (sz != 0) begin
      e = (d == 0) ? q_a[0] : q_b[0];
      if (e.cyc < cyc) begin
        n_vec++;
        n_bad++;
        $display("FAIL missing_event dut%0d: nothing seen, expected strobe at cycle %0d (now %0d)", d, e.cyc, cyc);
        if (d == 0) void'(q_a.pop_front());
        else void'(q_b.pop_front());
        sz--;
      end
    end
    if (rdy || err || wp) begin
      if (sz == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_event dut%0d: rdy=%0b wp=%0b err=%0b, expected none at cycle %0d", d, rdy, wp, err, cyc);
      end else begin
        e = (d == 0) ? q_a.pop_front() : q_b.pop_front();
        chk($sformatf("latency_dut%0d", d), 32'(cyc), 32'(e.cyc));
        chk($sformatf("strobes_dut%0d", d), {29'd0, rdy, wp, err}, {29'd0, !e.err, e.wp, e.err});
        chk($sformatf("read_data_dut%0d", d), 32'(dout), 32'(e.dout));
        chk($sformatf("rd_count_dut%0d", d), 32'(rdc), 32'(e.rdc));
        chk($sformatf("wr_count_dut%0d", d), 32'(wrc), 32'(e.wrc));
      end
    end
  endtask

  always @(negedge clk) begin
    check_port(0, rdy_a, wp_a, err_a, dout_a, rdc_a, wrc_a);
    check_port(1, rdy_b, wp_b, err_b, dout_b, 16'(rdc_b), 16'(wrc_b));
  end

  // kind: 0 read, 1 write, 2 both strobes (bus error). Request is held h cycles
  // while address/data are scrambled, then released.
  task automatic access(int d, int kind, logic [15:0] addr, logic [7:0] data, int h);
    exp_t e;
    int   n, tgt;
    n = (kind == 0) ? rd_wait[d] : ((kind == 1) ? wr_wait[d] : 0);
    @(negedge clk);
    drive(d, kind != 1, kind != 0, addr, data);
    e.err = 1'b0;
    e.wp  = 1'b0;
    e.rd  = (kind == 0);
    e.cyc = cyc + 2 + n;
    if (kind == 2) begin
      e.err = 1'b1;
      e.cyc = cyc + 1;
    end else if (kind == 0) begin
      m_dout[d] = mmem[d][addr];
      m_rdc[d]  = inc_sat(m_rdc[d], cnt_max[d]);
    end else begin
      e.wp = in_rom(addr);
      if (!e.wp) mmem[d][addr] = data;
      m_wrc[d] = inc_sat(m_wrc[d], cnt_max[d]);
    end
    e.dout = m_dout[d];
    e.rdc  = m_rdc[d];
    e.wrc  = m_wrc[d];
    if (d == 0) q_a.push_back(e);
    else q_b.push_back(e);
    for (int j = 1; j < h; j++) begin
      @(negedge clk);
      drive(d, kind != 1, (kind == 1) || (kind == 2 && j < 2), 16'($urandom), 8'($urandom));
    end
    @(negedge clk);
    drive(d, 1'b0, 1'b0, 16'($urandom), 8'($urandom));
    tgt = ((n + 3 > h + 1) ? n + 3 : h + 1) + int'($urandom_range(0, 2));
    repeat (tgt - h - 1) @(negedge clk);
  endtask

  task automatic do_reset(int d);
    @(negedge clk);
    set_rst(d, 1'b1);
    drive(d, 1'b0, 1'b0, 16'h0000, 8'h00);
    repeat (2) @(negedge clk);
    set_rst(d, 1'b0);
    model_reset(d);
    if (d == 0) begin
      chk("reset_strobes_dut0", {29'd0, rdy_a, wp_a, err_a}, 32'd0);
      chk("reset_dout_dut0", 32'(dout_a), 32'(m_dout[0]));
      chk("reset_counts_dut0", {rdc_a, wrc_a}, {16'(m_rdc[0]), 16'(m_wrc[0])});
    end else begin
      chk("reset_strobes_dut1", {29'd0, rdy_b, wp_b, err_b}, 32'd0);
      chk("reset_dout_dut1", 32'(dout_b), 32'(m_dout[1]));
      chk("reset_counts_dut1", {28'd0, rdc_b, wrc_b}, {28'd0, 2'(m_rdc[1]), 2'(m_wrc[1])});
    end
  endtask

  task automatic random_traffic(int d, int count);
    logic [15:0] pool [9];
    logic [15:0] a;
    int          k;
    pool = '{16'h0000, 16'h0102, 16'h1000, 16'hFFEF, 16'hFFF0, 16'hFFF7, 16'hFFFE, 16'hFFFF, 16'h2000};
    for (int i = 0; i < count; i++) begin
      k = int'($urandom_range(0, 9));
      a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : pool[$urandom_range(0, 8)];
      access(d, (k == 0) ? 2 : (k & 1), a, 8'($urandom), int'($urandom_range(1, 4)));
    end
  endtask

  task automatic thread_a();
    do_reset(0);
    access(0, 1, 16'h1000, 8'h8E, 1);
    access(0, 0, 16'h1000, 8'h00, 4);
    access(0, 1, 16'h0102, 8'h5A, 1);
    access(0, 0, 16'h0102, 8'h00, 2);
    access(0, 1, 16'hFFFE, 8'h00, 1);
    access(0, 0, 16'hFFFE, 8'h00, 1);
    access(0, 2, 16'h0000, 8'h77, 5);
    access(0, 1, 16'hFFEF, 8'h3C, 3);
    access(0, 0, 16'hFFEF, 8'h00, 1);
    access(0, 1, 16'hFFFF, 8'hC3, 1);
    access(0, 0, 16'hFFFF, 8'h00, 1);
    random_traffic(0, 150);
  endtask

  task automatic thread_b();
    do_reset(1);
    access(1, 0, 16'h2000, 8'h00, 1);
    // Read aborted by reset during its second wait cycle.
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 16'h2000, 8'h00);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 16'h2000, 8'h00);
    @(negedge clk);
    set_rst(1, 1'b1);
    @(negedge clk);
    set_rst(1, 1'b0);
    model_reset(1);
    chk("abort_dout_dut1", 32'(dout_b), 32'(m_dout[1]));
    chk("abort_rd_count_dut1", 32'(rdc_b), 32'(m_rdc[1]));
    repeat (6) @(negedge clk);
    access(1, 0, 16'h2000, 8'h00, 1);
    do_reset(1);
    for (int i = 0; i < 5; i++) access(1, 0, 16'($urandom), 8'h00, 1);
    access(1, 1, 16'hFFFE, 8'h00, 2);
    access(1, 0, 16'hFFFE, 8'h00, 1);
    access(1, 2, 16'h0000, 8'h00, 3);
    random_traffic(1, 80);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mmem[0][i] = 8'hA5;
      mmem[1][i] = 8'h10;
    end
    model_reset(0);
    model_reset(1);
    fork
      thread_a();
      thread_b();
    join
    repeat (10) @(negedge clk);
    chk("queue_drained_dut0", 32'(q_a.size()), 32'd0);
    chk("queue_drained_dut1", 32'(q_b.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    n_bad++;
    $display("FAIL watchdog: run still active at cycle %0d, expected completion", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wait_state_memory.md
WAIT_STATE_MEMORY -- requirements
Module: wait_state_memory

Interface
REQ-001 Parameter ADDR_W, default 16, address width in bits; array depth SHALL be 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 8, data word width in bits.
REQ-003 Parameter RD_WAIT, default 1, number of wait cycles inserted on reads (range 0-15).
REQ-004 Parameter WR_WAIT, default 0, number of wait cycles inserted on writes (range 0-15).
REQ-005 Parameter ROM_BASE, default 16'hFFF0, base address of the write-protected region; it SHALL be aligned to ROM_SIZE.
REQ-006 Parameter ROM_SIZE, default 16, size in words of the write-protected region; it SHALL be a power of two.
REQ-007 Parameter FILL, default 8'hA5, power-up content of every array word.
REQ-008 Parameter CNT_W, default 16, width of the access counters.
REQ-009 cpu_clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-010 cpu_reset  in  1  synchronous, active-high reset.
REQ-011 cpu_oe_i  in  1  read request, active-high, level.
REQ-012 cpu_we_i  in  1  write request, active-high, level.
REQ-013 cpu_addr_i  in  ADDR_W  access address.
REQ-014 cpu_data_i  in  DATA_W  write data.
REQ-015 cpu_data_o  out  DATA_W  registered read data.
REQ-016 mem_ready_o  out  1  one-cycle access-complete strobe.
REQ-017 wp_fault_o  out  1  one-cycle strobe flagging a write into the protected region.
REQ-018 bus_err_o  out  1  one-cycle strobe flagging cpu_oe_i and cpu_we_i asserted together.
REQ-019 rd_count_o  out  CNT_W  count of completed reads.
REQ-020 wr_count_o  out  CNT_W  count of completed write accesses, including protected ones.

Function
REQ-021 The block SHALL implement the FSM states IDLE, WAIT, ACK and HOLD.
REQ-022 In IDLE, when exactly one of cpu_oe_i or cpu_we_i is high, the block SHALL latch the address, data and access kind.
REQ-023 On that request, the wait counter SHALL load RD_WAIT or WR_WAIT as matching the access kind.
REQ-024 On that request, the next state SHALL be WAIT if the loaded count is nonzero, else ACK.
REQ-025 In IDLE, if cpu_oe_i and cpu_we_i are both high, there SHALL be no access; bus_err_o SHALL pulse for 1 cycle and the next state SHALL be HOLD.
REQ-026 In WAIT, the counter SHALL decrement each cycle; the FSM SHALL move to ACK in the cycle the counter reaches 1.
REQ-027 WAIT SHALL last exactly N cycles, where N is the loaded count.
REQ-028 Address and data changes after the IDLE sample SHALL be ignored, because the latched values are used.
REQ-029 In ACK, mem_ready_o SHALL be high for exactly one cycle, and the FSM SHALL then enter HOLD.
REQ-030 On a read in ACK, cpu_data_o SHALL update with mem[latched addr], valid in the same cycle mem_ready_o is high.
REQ-031 cpu_data_o SHALL otherwise hold its last value.
REQ-032 On a write in ACK, mem[latched addr] SHALL take the latched data unless the address is in the protected range [ROM_BASE, ROM_BASE+ROM_SIZE-1].
REQ-033 A write in the protected range SHALL leave the array unchanged and pulse wp_fault_o together with mem_ready_o.
REQ-034 Latency: for a request sampled at rising edge k, mem_ready_o SHALL be high in the cycle following edge k+1+N.
REQ-035 HOLD SHALL persist until cpu_oe_i and cpu_we_i are both low, then return to IDLE, so that a held level cannot start a second access.
REQ-036 rd_count_o SHALL increment in the read ACK cycle; wr_count_o SHALL increment in the write ACK cycle.
REQ-037 Both counters SHALL saturate at all-ones and never wrap.
REQ-038 Address arithmetic SHALL be ADDR_W bits wide; the protected-range compare SHALL not overflow when ROM_BASE+ROM_SIZE equals 2**ADDR_W.
REQ-039 The array SHALL power up with every word equal to FILL.

Reset
REQ-040 On cpu_reset, the FSM SHALL go to IDLE and the wait counter SHALL clear.
REQ-041 On cpu_reset, cpu_data_o, mem_ready_o, wp_fault_o, bus_err_o, rd_count_o and wr_count_o SHALL all clear to 0.
REQ-042 The array contents SHALL NOT be affected by reset.
REQ-043 A reset asserted in WAIT or ACK SHALL abort the access: no array write, no ready strobe, no counter increment.
REQ-044 Reset SHALL take priority over every simultaneous request.

Verification
REQ-045 Default parameters, preload mem[1000]=8E, cpu_oe_i high at 1000 for 4 cycles -> mem_ready_o high exactly 1 cycle, 2 cycles after the sampling edge; cpu_data_o=8E; rd_count_o=1.
REQ-046 Write 0102=5A with WR_WAIT=0, then read 0102 -> ready on the cycle after the write sample, read returns 5A, wr_count_o=1, rd_count_o=1.
REQ-047 Write FFFE=00 -> wp_fault_o and mem_ready_o pulse together; a subsequent read of FFFE returns its preloaded value (10).
REQ-048 cpu_oe_i and cpu_we_i high together -> bus_err_o pulse, no ready, counters unchanged, state returns to IDLE only after both inputs drop.
REQ-049 RD_WAIT=3, cpu_reset asserted in the second WAIT cycle of a read -> no ready, cpu_data_o=0, rd_count_o=0; a next read completes normally.
REQ-050 CNT_W=2, 5 reads -> rd_count_o sequence 1,2,3,3,3.
